// File: rtl/word_rx_pkg.sv
// Shared types and constants for the serial word receiver.
// FSM state encoding and the active-low 7-segment hex table ({g,f,e,d,c,b,a}).
package word_rx_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop,
        StBreak
    } rx_state_e;

    localparam logic [6:0] SEG_ZERO = 7'b1000000;

    localparam logic [6:0] SEG_LUT [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

endpackage

// File: rtl/hex7seg.sv
// Combinational 4-bit to active-low 7-segment hex decoder.
module hex7seg
    import word_rx_pkg::*;
(
    input  logic [3:0] hex_i,
    output logic [6:0] seg_n_o
);

    assign seg_n_o = SEG_LUT[hex_i];

endmodule

// File: rtl/word_rx.sv
// Serial word receiver: start bit, WORD_W data bits MSB first, stop bit.
// Shows the last good word on LEDs and a registered 7-segment digit.
module word_rx
    import word_rx_pkg::*;
#(
    parameter int unsigned BIT_TICKS = 50000,
    parameter int unsigned WORD_W    = 4,
    parameter int unsigned CNT_W     = 8
) (
    input  logic              sysclk,
    input  logic              rst_n,
    input  logic              serial_in,
    output logic [WORD_W-1:0] word,
    output logic              word_valid,
    output logic              frame_err,
    output logic              busy,
    output logic [CNT_W-1:0]  word_count,
    output logic [6:0]        seg_n
);

    localparam int unsigned TickW = $clog2(BIT_TICKS);
    localparam int unsigned IdxW  = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam logic [TickW-1:0] TickLast = TickW'(BIT_TICKS - 1);
    localparam logic [TickW-1:0] TickHalf = TickW'(BIT_TICKS / 2 - 1);
    localparam logic [IdxW-1:0]  IdxLast  = IdxW'(WORD_W - 1);

    logic [1:0] rst_sync_q;
    logic       rst_s_n;
    logic [1:0] rx_sync_q;
    logic       rx_s;

    rx_state_e         state_q, state_d;
    logic [TickW-1:0]  tick_q, tick_d;
    logic [IdxW-1:0]   idx_q, idx_d;
    logic [WORD_W-1:0] shift_q, shift_d;
    logic [WORD_W-1:0] word_q, word_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              valid_q, valid_d;
    logic              err_q, err_d;
    logic [6:0]        seg_q, seg_raw;
    logic              half_done, bit_done;

    // Reset asserts asynchronously but releases on a clock edge.
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end
    assign rst_s_n = rst_sync_q[1];

    always_ff @(posedge sysclk or negedge rst_s_n) begin
        if (!rst_s_n) begin
            rx_sync_q <= 2'b11;
            state_q   <= StIdle;
            tick_q    <= '0;
            idx_q     <= '0;
            shift_q   <= '0;
            word_q    <= '0;
            count_q   <= '0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
            seg_q     <= SEG_ZERO;
        end else begin
            rx_sync_q <= {rx_sync_q[0], serial_in};
            state_q   <= state_d;
            tick_q    <= tick_d;
            idx_q     <= idx_d;
            shift_q   <= shift_d;
            word_q    <= word_d;
            count_q   <= count_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
            seg_q     <= seg_raw;
        end
    end
    assign rx_s = rx_sync_q[1];

    assign half_done = (tick_q == TickHalf);
    assign bit_done  = (tick_q == TickLast);

    always_comb begin : next_state
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (!rx_s) state_d = StStart;
            StStart: if (half_done) state_d = rx_s ? StIdle : StData;
            StData:  if (bit_done && idx_q == '0) state_d = StStop;
            StStop:  if (bit_done) state_d = rx_s ? StIdle : StBreak;
            StBreak: if (rx_s) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin : outputs
        tick_d  = tick_q + 1'b1;
        idx_d   = idx_q;
        shift_d = shift_q;
        word_d  = word_q;
        count_d = count_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        busy    = (state_q != StIdle);
        unique case (state_q)
            StIdle: tick_d = '0;
            StStart: begin
                if (half_done) begin
                    tick_d = '0;
                    idx_d  = IdxLast;
                end
            end
            StData: begin
                if (bit_done) begin
                    tick_d  = '0;
                    shift_d = {shift_q[WORD_W-2:0], rx_s};
                    idx_d   = idx_q - 1'b1;
                end
            end
            StStop: begin
                if (bit_done) begin
                    tick_d = '0;
                    if (rx_s) begin
                        word_d  = shift_q;
                        count_d = count_q + 1'b1;
                        valid_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            StBreak: tick_d = '0;
            default: tick_d = '0;
        endcase
    end

    hex7seg u_hex7seg (
        .hex_i   (word_q[3:0]),
        .seg_n_o (seg_raw)
    );

    assign word       = word_q;
    assign word_valid = valid_q;
    assign frame_err  = err_q;
    assign word_count = count_q;
    assign seg_n      = seg_q;

endmodule

// File: tb/tb_word_rx.sv
// Directed bench for word_rx with BIT_TICKS=8.
module tb_word_rx;

    localparam int unsigned BT = 8;

    logic       sysclk = 1'b0;
    logic       rst_n;
    logic       serial_in;
    logic [3:0] word;
    logic       word_valid;
    logic       frame_err;
    logic       busy;
    logic [7:0] word_count;
    logic [6:0] seg_n;

    int n_checks = 0;
    int n_errors = 0;

    int cyc = 0;
    int n_valid = 0;
    int n_ferr = 0;
    int last_valid_cyc = 0;
    logic [3:0] words [$];

    word_rx #(
        .BIT_TICKS (BT),
        .WORD_W    (4),
        .CNT_W     (8)
    ) dut (
        .sysclk     (sysclk),
        .rst_n      (rst_n),
        .serial_in  (serial_in),
        .word       (word),
        .word_valid (word_valid),
        .frame_err  (frame_err),
        .busy       (busy),
        .word_count (word_count),
        .seg_n      (seg_n)
    );

    always #5 sysclk = ~sysclk;

    always @(posedge sysclk) cyc <= cyc + 1;

    always @(negedge sysclk) begin
        if (word_valid) begin
            n_valid        <= n_valid + 1;
            last_valid_cyc <= cyc;
            words.push_back(word);
        end
        if (frame_err) n_ferr <= n_ferr + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge sysclk);
            #1;
        end
    endtask

    task automatic send_bit(input logic b);
        serial_in = b;
        step(BT);
    endtask

    task automatic send_frame(input logic [3:0] d, input logic stop);
        send_bit(1'b0);
        for (int i = 3; i >= 0; i--) send_bit(d[i]);
        send_bit(stop);
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        serial_in = 1'b1;
        step(4);
        rst_n = 1'b1;
        step(10);
    endtask

    int v0, e0, t0, lat;

    initial begin
        rst_n = 1'b0;
        serial_in = 1'b1;
        step(5);
        rst_n = 1'b1;
        step(100);
        check("rst_word", word, 0);
        check("rst_count", word_count, 0);
        check("rst_valid", n_valid, 0);
        check("rst_ferr", n_ferr, 0);
        check("rst_seg", seg_n, 7'b1000000);
        check("rst_busy", busy, 0);

        // Single frame 4'hB
        v0 = n_valid;
        e0 = n_ferr;
        t0 = cyc;
        send_frame(4'hB, 1'b1);
        step(4);
        lat = last_valid_cyc - t0;
        check("b_pulses", n_valid - v0, 1);
        check("b_latency_44_50", (lat >= 44 && lat <= 50), 1);
        check("b_word", word, 4'hB);
        check("b_count", word_count, 1);
        check("b_seg", seg_n, 7'b0000011);
        check("b_ferr", n_ferr - e0, 0);

        // Back-to-back frames from a fresh reset
        reset_dut();
        words.delete();
        v0 = n_valid;
        send_frame(4'h1, 1'b1);
        send_frame(4'hF, 1'b1);
        send_frame(4'h0, 1'b1);
        step(4);
        check("b2b_pulses", n_valid - v0, 3);
        check("b2b_w0", (words.size() > 0) ? words[0] : 4'hx, 4'h1);
        check("b2b_w1", (words.size() > 1) ? words[1] : 4'hx, 4'hF);
        check("b2b_w2", (words.size() > 2) ? words[2] : 4'hx, 4'h0);
        check("b2b_word", word, 4'h0);
        check("b2b_count", word_count, 3);
        check("b2b_seg", seg_n, 7'b1000000);

        // Short low glitch on idle line
        v0 = n_valid;
        e0 = n_ferr;
        serial_in = 1'b0;
        step(3);
        serial_in = 1'b1;
        step(20);
        check("gl_valid", n_valid - v0, 0);
        check("gl_ferr", n_ferr - e0, 0);
        check("gl_busy", busy, 0);
        check("gl_count", word_count, 3);

        // Bad stop bit, line held low, then a good frame
        v0 = n_valid;
        e0 = n_ferr;
        send_frame(4'h5, 1'b0);
        step(50);
        check("brk_busy", busy, 1);
        serial_in = 1'b1;
        step(10);
        check("brk_ferr", n_ferr - e0, 1);
        check("brk_valid", n_valid - v0, 0);
        check("brk_word", word, 4'h0);
        check("brk_count", word_count, 3);
        check("brk_idle", busy, 0);
        send_frame(4'hA, 1'b1);
        step(4);
        check("a_word", word, 4'hA);
        check("a_count", word_count, 4);
        check("a_seg", seg_n, 7'b0001000);

        // Reset in the middle of frame 4'hC
        v0 = n_valid;
        send_bit(1'b0);
        send_bit(1'b1);
        serial_in = 1'b1;
        step(BT / 2);
        check("mid_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_word", word, 0);
        check("mid_rst_count", word_count, 0);
        check("mid_rst_seg", seg_n, 7'b1000000);
        check("mid_rst_busy", busy, 0);
        step(3);
        rst_n = 1'b1;
        step(20);
        check("mid_valid", n_valid - v0, 0);
        send_frame(4'h3, 1'b1);
        step(4);
        check("post_word", word, 4'h3);
        check("post_count", word_count, 1);
        check("post_seg", seg_n, 7'b0110000);
        check("post_pulses", n_valid - v0, 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/word_rx.md
Name: word_rx

Overview:
- Serial word receiver directly downstream of wordgen.
- Consumes wordgen's single-bit `out` line (the `serial_in` port here) and recovers each 4-bit word.
- Presents the last good word on LEDs and a 7-segment digit, and pulses a strobe per received word.
- Flags malformed frames so board-level checks can confirm wordgen's write/auto operation end to end.

Parameters:
- BIT_TICKS, 50000, sysclk cycles per serial bit (1 ms at 50 MHz); must be even and >= 4.
- WORD_W, 4, data bits per frame (one per wordgen switch sw1..sw4).
- CNT_W, 8, width of the received-word counter.

Ports:
- sysclk  input  1  system clock, 50 MHz, rising edge.
- rst_n  input  1  asynchronous active-low reset; deassertion is synchronised internally.
- serial_in  input  1  serial line from wordgen `out`; asynchronous to the receiver, idle high.
- word  output  WORD_W  last correctly framed word, MSB = sw1.
- word_valid  output  1  one-cycle pulse when `word` updates.
- frame_err  output  1  one-cycle pulse on stop-bit failure.
- busy  output  1  high while a frame is in progress (any state other than IDLE).
- word_count  output  CNT_W  number of good words received; wraps.
- seg_n  output  7  active-low 7-segment pattern (a..g) of `word` as a hex digit.

Behaviour:
- Frame format (fixed): idle = 1; start bit = 0; WORD_W data bits MSB first; stop bit = 1. Each bit is held for BIT_TICKS cycles.
- Input conditioning: serial_in passes through a 2-flop synchroniser, reset to 1. All logic uses the synchronised value `rx_s`.
- Reset values: word=0, word_valid=0, frame_err=0, busy=0, word_count=0, seg_n = pattern for "0" (7'b1000000), FSM in IDLE, tick counter 0, bit index 0.
- FSM states:
  - IDLE: on rx_s == 0 -> START, tick counter cleared.
  - START: count BIT_TICKS/2 cycles, then re-sample. If rx_s == 0 -> DATA, bit index = WORD_W-1, tick counter cleared. If rx_s == 1 -> IDLE (glitch rejected, no outputs change).
  - DATA: every BIT_TICKS cycles (bit centre), shift rx_s into the shift register, then decrement the bit index. After the sample at index 0 -> STOP.
  - STOP: after BIT_TICKS cycles, sample. If rx_s == 1: `word` <= shift register, word_valid = 1 for exactly that cycle, word_count += 1 (wrapping 2^CNT_W-1 -> 0), -> IDLE. If rx_s == 0: frame_err = 1 for one cycle, word and word_count unchanged, -> BREAK.
  - BREAK: wait for rx_s == 1, then -> IDLE. A line held low (e.g. wordgen mid-reset) produces only one frame_err.
- Latency: word_valid asserts (1.5 + WORD_W) * BIT_TICKS cycles (±1) after the start-bit falling edge reaches `rx_s`, plus 2 cycles of synchroniser delay.
- Back-to-back frames are accepted: a start bit that begins the cycle after the stop sample is detected from IDLE with no extra gap.
- seg_n is registered from `word` and updates the cycle after word_valid.
- Tick counter width is $clog2(BIT_TICKS). There is no counter overflow path.
- Async reset mid-frame returns to IDLE immediately and discards the partial word. After reset release, a line already low is treated as a start bit only after being seen high first; reset places the FSM in IDLE with rx_s forced to 1, so a falling edge is required.

Decomposition:
- Package word_rx_pkg: FSM state enum (IDLE, START, DATA, STOP, BREAK) and the 7-segment hex lookup constants.
- Sub-module hex7seg: pure combinational 4-bit -> 7-bit active-low decoder. It is instantiated once and its output registered in word_rx.

Test Plan (BIT_TICKS=8 for simulation):
- Reset held low, then released; line idle high for 100 cycles -> word=0, word_count=0, no word_valid, no frame_err, seg_n=7'b1000000.
- Send frame 0,1,0,1,1,1 (data 4'b1011) -> single word_valid pulse about 46 cycles after the start edge; word=4'hB, word_count=1, seg_n = "b" pattern.
- Three back-to-back frames 4'h1, 4'hF, 4'h0 with no idle gap -> three word_valid pulses; final word=0, word_count=3.
- Low glitch of 3 cycles on an idle line -> FSM returns to IDLE; no word_valid, no frame_err.
- Frame 4'h5 with stop bit forced 0, line held low 50 cycles, then high -> exactly one frame_err; word keeps its previous value. A following good frame 4'hA is received correctly.
- Assert rst_n mid-DATA during frame 4'hC -> outputs return to reset values; no word_valid. The next full frame 4'h3 is received with word_count=1.
